// File: rtl/collision_event_filter_pkg.sv
// Shared constants and state encoding for the collision event filter.
package collision_event_filter_pkg;

  localparam int HOLDOFF_FRAMES_DEFAULT = 8;
  localparam int HOLDOFF_W_DEFAULT      = 4;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    REPORT = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/collision_event_filter_if.sv
// Pixel-overlap inputs from the drawing pipeline and collision event outputs to the game controller.
interface collision_event_filter_if;

  logic startOfFrame;
  logic smileyDrawingRequest;
  logic borderBottomDrawingRequest;
  logic obstacleDrawingRequest;
  logic obstacleIsGood;
  logic pause;
  logic collisionSmileyBorderBottom;
  logic collisionSmileyObstacle;
  logic collisionSmileyObstacleGood;
  logic collisionSmileyObstacleBad;

  modport master (
    output startOfFrame, smileyDrawingRequest, borderBottomDrawingRequest,
           obstacleDrawingRequest, obstacleIsGood, pause,
    input  collisionSmileyBorderBottom, collisionSmileyObstacle,
           collisionSmileyObstacleGood, collisionSmileyObstacleBad
  );

  modport slave (
    input  startOfFrame, smileyDrawingRequest, borderBottomDrawingRequest,
           obstacleDrawingRequest, obstacleIsGood, pause,
    output collisionSmileyBorderBottom, collisionSmileyObstacle,
           collisionSmileyObstacleGood, collisionSmileyObstacleBad
  );

endinterface

// File: rtl/collision_event_filter_frame_sticky_flag.sv
// Per-frame sticky hit flag: sets on a hit, restarts at each frame boundary.
module frame_sticky_flag (
  input  logic clk,
  input  logic resetN,
  input  logic set,
  input  logic boundary,
  input  logic clear,
  output logic flag
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (boundary) begin
      // A hit on the boundary cycle belongs to the frame that is just starting.
      flag <= set;
    end else if (set) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/collision_event_filter.sv
// Turns per-pixel overlap requests into single-cycle, once-per-frame collision events with obstacle holdoff.
module collision_event_filter
  import collision_event_filter_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEFAULT,
  parameter int HOLDOFF_W      = HOLDOFF_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetN,
  collision_event_filter_if.slave  bus
);

  state_t               state;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 hit_bottom, hit_good, hit_bad;
  logic                 pix_bottom, pix_good, pix_bad;
  logic                 bottom_q, obstacle_q, good_q, bad_q;

  assign pix_bottom = bus.smileyDrawingRequest & bus.borderBottomDrawingRequest;
  assign pix_good   = bus.smileyDrawingRequest & bus.obstacleDrawingRequest &  bus.obstacleIsGood;
  assign pix_bad    = bus.smileyDrawingRequest & bus.obstacleDrawingRequest & ~bus.obstacleIsGood;

  frame_sticky_flag u_flag_bottom (
    .clk(clk), .resetN(resetN), .set(pix_bottom), .boundary(bus.startOfFrame),
    .clear(bus.pause), .flag(hit_bottom)
  );

  frame_sticky_flag u_flag_good (
    .clk(clk), .resetN(resetN), .set(pix_good), .boundary(bus.startOfFrame),
    .clear(bus.pause), .flag(hit_good)
  );

  frame_sticky_flag u_flag_bad (
    .clk(clk), .resetN(resetN), .set(pix_bad), .boundary(bus.startOfFrame),
    .clear(bus.pause), .flag(hit_bad)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ACCUM;
      holdoff    <= '0;
      bottom_q   <= 1'b0;
      obstacle_q <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first, so every event output is a one-cycle pulse unless overridden below.
      bottom_q   <= 1'b0;
      obstacle_q <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      if (bus.pause) begin
        state   <= PAUSED;
        holdoff <= '0;
      end else if (bus.startOfFrame && state != PAUSED) begin
        state <= REPORT;
        if (hit_bottom) begin
          bottom_q <= 1'b1;
          if (holdoff != '0) holdoff <= holdoff - 1'b1;
        end else if ((hit_good || hit_bad) && holdoff == '0) begin
          obstacle_q <= 1'b1;
          good_q     <= hit_good;
          bad_q      <= hit_bad & ~hit_good;
          holdoff    <= HOLDOFF_W'(HOLDOFF_FRAMES);
        end else if (holdoff != '0) begin
          holdoff <= holdoff - 1'b1;
        end
      end else begin
        state <= ACCUM;
      end
    end
  end

  assign bus.collisionSmileyBorderBottom = bottom_q;
  assign bus.collisionSmileyObstacle     = obstacle_q;
  assign bus.collisionSmileyObstacleGood = good_q;
  assign bus.collisionSmileyObstacleBad  = bad_q;

endmodule

// File: tb/tb_collision_event_filter.sv
// Scoreboard bench: a frame-level reference model queues expected events; a negedge monitor checks the DUT.
module tb_collision_event_filter;

  localparam int HF = 8;

  typedef struct {
    int         cyc;
    logic [3:0] ev;   // {bottom, obstacle, good, bad}
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  collision_event_filter_if bus ();

  collision_event_filter #(.HOLDOFF_FRAMES(HF), .HOLDOFF_W(4)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs_seen = 0;

  // Reference model: per-frame hit sets and the boundary index of the last obstacle report.
  bit m_bottom, m_good, m_bad;
  int bidx = 0;
  int last_obs = 0;
  bit last_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sof, input bit sm, input bit bb, input bit ob,
                       input bit og, input bit pz);
    @(posedge clk);
    #1;
    bus.startOfFrame               = sof;
    bus.smileyDrawingRequest       = sm;
    bus.borderBottomDrawingRequest = bb;
    bus.obstacleDrawingRequest     = ob;
    bus.obstacleIsGood             = og;
    bus.pause                      = pz;
    if (pz) begin
      m_bottom = 0; m_good = 0; m_bad = 0;
      last_valid = 0;
    end else if (sof) begin
      if (m_bottom) begin
        q.push_back('{cyc + 1, 4'b1000});
      end else if ((m_good || m_bad) && (!last_valid || (bidx - last_obs) > HF)) begin
        q.push_back('{cyc + 1, {1'b0, 1'b1, m_good, m_bad && !m_good}});
        last_obs   = bidx;
        last_valid = 1;
      end
      bidx++;
      m_bottom = sm && bb;
      m_good   = sm && ob && og;
      m_bad    = sm && ob && !og;
    end else begin
      m_bottom = m_bottom || (sm && bb);
      m_good   = m_good   || (sm && ob && og);
      m_bad    = m_bad    || (sm && ob && !og);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  // n pixels of one overlap pattern, then the frame boundary.
  task automatic frame(input int n, input bit sm, input bit bb, input bit ob, input bit og);
    repeat (n) drive(0, sm, bb, ob, og, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle(2);
    @(posedge clk);
    #1;
    resetN = 1'b0;
    m_bottom = 0; m_good = 0; m_bad = 0;
    last_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] ev;
    ev = {bus.collisionSmileyBorderBottom, bus.collisionSmileyObstacle,
          bus.collisionSmileyObstacleGood, bus.collisionSmileyObstacleBad};
    if (!resetN) begin
      check("reset_outputs", int'(ev), 0);
    end else if (ev != 4'b0000) begin
      if (ev[2]) obs_seen++;
      check("good_bad_onehot", int'(ev[1] ^ ev[0]), int'(ev[2]));
      if (q.size() == 0) begin
        check("unexpected_pulse", int'(ev), 0);
      end else begin
        e = q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_kind", int'(ev), int'(e.ev));
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check("missing_pulse", 0, int'(e.ev));
    end
  end

  initial begin : stimulus
    int base;
    bus.startOfFrame = 0; bus.smileyDrawingRequest = 0; bus.borderBottomDrawingRequest = 0;
    bus.obstacleDrawingRequest = 0; bus.obstacleIsGood = 0; bus.pause = 0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;

    // Single good-obstacle frame.
    idle(1);
    frame(50, 1, 0, 1, 1);
    idle(3);

    // Good overlap held for 12 frames: reports at boundaries 1 and 10 only.
    do_reset();
    base = obs_seen;
    repeat (12) frame(10, 1, 0, 1, 1);
    idle(3);
    check("holdoff_report_count", obs_seen - base, 2);

    // Bottom and bad obstacle in one frame, then bad alone next frame.
    do_reset();
    repeat (5) drive(0, 1, 1, 0, 0, 0);
    frame(5, 1, 0, 1, 0);
    frame(6, 1, 0, 1, 0);
    idle(3);

    // Good and bad pixels in one frame.
    do_reset();
    repeat (4) drive(0, 1, 0, 1, 0, 0);
    frame(4, 1, 0, 1, 1);
    idle(3);

    // Hit coincident with startOfFrame counts toward the next frame.
    do_reset();
    idle(8);
    drive(1, 1, 0, 1, 1, 0);
    frame(8, 0, 0, 0, 0);
    idle(3);

    // Pause clears holdoff; pulses suppressed while paused.
    do_reset();
    frame(6, 1, 0, 1, 1);
    idle(2);
    repeat (3) begin
      repeat (6) drive(0, 1, 1, 1, 1, 1);
      drive(1, 1, 0, 1, 1, 1);
    end
    frame(6, 1, 0, 1, 0);
    idle(3);

    // Reset mid-frame discards accumulated hits.
    do_reset();
    repeat (10) drive(0, 1, 0, 1, 1, 0);
    do_reset();
    frame(10, 0, 0, 0, 0);
    idle(3);

    // Randomized frames: mixed overlaps, pauses, back-to-back boundaries.
    do_reset();
    for (int f = 0; f < 80; f++) begin
      int len;
      bit pz_frame;
      len      = ($urandom % 8 == 0) ? 0 : int'($urandom_range(3, 20));
      pz_frame = ($urandom % 10 == 0);
      for (int i = 0; i < len; i++) begin
        drive(0, ($urandom % 3 == 0), ($urandom % 12 == 0), ($urandom % 4 == 0),
              1'($urandom % 2), pz_frame || ($urandom % 40 == 0));
      end
      drive(1, ($urandom % 4 == 0), ($urandom % 8 == 0), ($urandom % 4 == 0),
            1'($urandom % 2), pz_frame);
    end
    idle(5);

    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
